// File: rtl/alu_pipe_if.sv
// Issue/result handshake bundle for alu_pipe.
// slave is the ALU's view; master is the issuer/consumer view.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             busy;

    modport slave (
        input  in_valid, A, B, sel, out_ready,
        output in_ready, out_valid, result, flags, busy
    );

    modport master (
        output in_valid, A, B, sel, out_ready,
        input  in_ready, out_valid, result, flags, busy
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes, {N,Z,C,V} flags and a
// WIDTH-cycle shift-add multiplier. One operation in flight at a time.
module alu_pipe #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input logic       clk,
    input logic       rst,
    alu_pipe_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               accept;
    logic [SHW-1:0]     shamt;
    logic [WIDTH:0]     wide;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic [2*WIDTH-1:0] acc_sum;

    assign bus.in_ready  = !rst && (state_q == StIdle) && (!out_valid_q || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign shamt         = bus.B[SHW-1:0];
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign bus.busy      = (state_q == StMul);

    // Single-cycle datapath; the extra bit of 'wide' carries C for add/sub/shifts.
    always_comb begin
        wide    = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.sel)
            3'b000: begin
                wide    = {1'b0, bus.A} + {1'b0, bus.B};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != bus.A[WIDTH-1]);
            end
            3'b001: begin
                wide    = {1'b0, bus.A} - {1'b0, bus.B};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != bus.A[WIDTH-1]);
            end
            3'b010: alu_res = bus.A & bus.B;
            3'b011: alu_res = bus.A | bus.B;
            3'b100: alu_res = bus.A ^ bus.B;
            3'b101: begin
                wide    = {1'b0, bus.A} << shamt;
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            3'b110: begin
                wide    = {bus.A, 1'b0} >> shamt;
                alu_res = wide[WIDTH:1];
                alu_c   = wide[0];
            end
            default: ;
        endcase
    end

    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (bus.sel == 3'b111) begin
                        state_d     = StMul;
                        out_valid_d = 1'b0;
                        acc_d       = '0;
                        mcand_d     = {{WIDTH{1'b0}}, bus.A};
                        mplier_d    = bus.B;
                        cnt_d       = CW'(WIDTH);
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        flags_d     = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
                    end
                end else if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            StMul: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b1;
                    result_d    = acc_sum[WIDTH-1:0];
                    flags_d     = {acc_sum[WIDTH-1], acc_sum[WIDTH-1:0] == '0,
                                   |acc_sum[2*WIDTH-1:WIDTH], 1'b0};
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a transaction-level model checks the outputs
// every cycle, and literal expectations pin the model's arithmetic.
module tb_alu_pipe;
    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst;

    alu_pipe_if #(.WIDTH(W)) bus ();

    alu_pipe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int res;
        int flg;
        bit mul;
        int due;
    } exp_t;

    exp_t q[$];

    // Expected outcome from plain integer arithmetic on the operands.
    function automatic exp_t model(input int a, input int b, input int s, input int now);
        exp_t e;
        int   m    = (1 << W) - 1;
        int   half = 1 << (W - 1);
        int   sa, sb, r, sh, p;
        bit   c, v;
        sa = (a >= half) ? a - (1 << W) : a;
        sb = (b >= half) ? b - (1 << W) : b;
        sh = b & (W - 1);
        r  = 0;
        c  = 0;
        v  = 0;
        case (s)
            0: begin r = a + b; c = (r > m); v = (sa + sb > half - 1) || (sa + sb < -half); end
            1: begin r = a - b; c = (a < b); v = (sa - sb > half - 1) || (sa - sb < -half); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = a << sh; c = (sh != 0) && (((a >> (W - sh)) & 1) != 0); end
            6: begin r = a >> sh; c = (sh != 0) && (((a >> (sh - 1)) & 1) != 0); end
            default: begin p = a * b; r = p; c = (p > m); end
        endcase
        r     = r & m;
        e.res = r;
        e.flg = ((r >= half) ? 8 : 0) | ((r == 0) ? 4 : 0) | (c ? 2 : 0) | (v ? 1 : 0);
        e.mul = (s == 7);
        e.due = now + ((s == 7) ? W + 1 : 1);
        return e;
    endfunction

    bit m_ov, m_bz, m_rdy;

    // Sampled at negedge: inputs are stable and describe what the next edge does.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            m_ov  = (q.size() > 0) && (cyc >= q[0].due);
            m_bz  = (q.size() > 0) && q[0].mul && (cyc < q[0].due);
            m_rdy = !m_bz && (!m_ov || bus.out_ready);
            chk("mon out_valid", bus.out_valid, m_ov);
            chk("mon busy", bus.busy, m_bz);
            chk("mon in_ready", bus.in_ready, m_rdy);
            if (m_ov) begin
                chk("mon result", bus.result, q[0].res);
                chk("mon flags", bus.flags, q[0].flg);
                if (bus.out_ready) void'(q.pop_front());
            end
            if (bus.in_valid && m_rdy) q.push_back(model(bus.A, bus.B, bus.sel, cyc));
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic offer(input int a, input int b, input int s);
        bus.A        = W'(a);
        bus.B        = W'(b);
        bus.sel      = 3'(s);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready) break;
            @(posedge clk);
            #1;
        end
        if (!bus.in_ready) chk("offer accepted", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic op_check(input string name, input int a, input int b, input int s,
                            input int res, input int flg);
        int lat  = 1;
        int bc   = 0;
        bit seen = 0;
        offer(a, b, s);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.busy) begin
                bc++;
                chk({name, " in_ready while busy"}, bus.in_ready, 0);
            end
            if (bus.out_valid) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, " out_valid seen"}, seen, 1);
        chk({name, " result"}, bus.result, res);
        chk({name, " flags"}, bus.flags, flg);
        chk({name, " latency"}, lat, (s == 7) ? W + 1 : 1);
        if (s == 7) chk({name, " busy cycles"}, bc, W);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    int lit[5] = '{4, 2, 1, 3, 2};

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.A         = '0;
        bus.B         = '0;
        bus.sel       = '0;
        #3;
        chk("reset in_ready", bus.in_ready, 0);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset result", bus.result, 0);
        chk("reset flags", bus.flags, 0);
        chk("reset busy", bus.busy, 0);
        #9;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ADD..XOR of 0011,0001 issued on consecutive edges
        bus.A        = 4'b0011;
        bus.B        = 4'b0001;
        bus.sel      = 3'd0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("b2b first in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) bus.sel = 3'(i + 1);
            else bus.in_valid = 1'b0;
            @(negedge clk);
            chk("b2b out_valid", bus.out_valid, 1);
            chk("b2b result", bus.result, lit[i]);
            chk("b2b flags", bus.flags, 0);
            if (i < 4) chk("b2b in_ready", bus.in_ready, 1);
            @(posedge clk);
            #1;
        end

        op_check("add ovf", 4'b0111, 4'b0001, 0, 4'b1000, 4'b1001);
        op_check("add carry", 4'b1111, 4'b0001, 0, 4'b0000, 4'b0110);
        op_check("sub borrow", 4'b0001, 4'b0011, 1, 4'b1110, 4'b1010);
        op_check("shl", 4'b1001, 4'b0001, 5, 4'b0010, 4'b0010);
        op_check("shr", 4'b1001, 4'b0010, 6, 4'b0010, 4'b0000);
        op_check("shr s0", 4'b1001, 4'b0100, 6, 4'b1001, 4'b1000);
        op_check("mul 3x5", 4'b0011, 4'b0101, 7, 4'b1111, 4'b1000);
        op_check("mul fxf", 4'b1111, 4'b1111, 7, 4'b0001, 4'b0010);

        // Backpressure: hold an ADD result while a second op waits
        bus.out_ready = 1'b0;
        offer(4'b0010, 4'b0011, 0);
        bus.A        = 4'b1000;
        bus.B        = 4'b0001;
        bus.sel      = 3'd3;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp out_valid", bus.out_valid, 1);
            chk("bp result", bus.result, 4'b0101);
            chk("bp flags", bus.flags, 0);
            chk("bp in_ready", bus.in_ready, 0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp drain in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp next out_valid", bus.out_valid, 1);
        chk("bp next result", bus.result, 4'b1001);
        chk("bp next flags", bus.flags, 4'b1000);
        @(posedge clk);
        #1;

        // Reset two edges into a multiply, between clock edges
        offer(4'b0011, 4'b0101, 7);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst busy", bus.busy, 0);
        chk("rst result", bus.result, 0);
        chk("rst in_ready", bus.in_ready, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            chk("post-rst out_valid", bus.out_valid, 0);
            chk("post-rst in_ready", bus.in_ready, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's 4-bit combinational ALU.
- Adds configurable WIDTH, valid/ready handshakes on input and output, status flags, shift ops and a multi-cycle shift-add multiplier.
- Sits between an operand-issue stage and a result-consumer stage. Accepts one operation at a time and holds its result until it is consumed.

Parameters:
- WIDTH, 4, operand/result width in bits (>=2, power of two).
- SHW, $clog2(WIDTH), shift-amount bits taken from B[SHW-1:0] (derived, do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  operation offered.
- in_ready  output  1  operation can be accepted this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- sel  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer takes result.
- result  output  WIDTH  registered result.
- flags  output  4  {N,Z,C,V}, registered with result.
- busy  output  1  multiplier iterating.

Behaviour:
- Reset (async, rst=1): state=IDLE; out_valid=0; result=0; flags=0; busy=0; in_ready=0 while rst high.
- FSM states: IDLE, MUL.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This allows back-to-back issue with same-edge drain.
- Accept = in_valid && in_ready at a rising edge. A, B and sel are sampled only on accept.
- Ops 000-110: single cycle. Result and flags are loaded on the accept edge; out_valid=1 after that edge (latency 1).
- MUL, on accept edge: capture A and B, clear the 2*WIDTH accumulator, load counter=WIDTH, go to MUL; busy=1, in_ready=0.
- MUL, in MUL state: each edge adds (B bit i ? A<<i : 0), i = 0..WIDTH-1.
- MUL, on the WIDTH-th edge in MUL: result=acc[WIDTH-1:0], flags loaded, out_valid=1, state=IDLE, busy=0.
- MUL latency: out_valid rises WIDTH+1 edges after accept.
- Output hold: while out_valid && !out_ready, result, flags and out_valid are stable and in_ready=0.
- Output drain: out_valid clears on the edge where out_ready=1, unless a new single-cycle op is accepted on the same edge. In that case out_valid stays 1 and the new result is loaded.
- Output-side completion (MUL entry): MUL is only entered from IDLE with in_ready=1. On that edge, out_valid is cleared if out_ready=1.
- ADD: {C,result} = A+B; V = signed overflow (A,B same sign, result sign differs).
- SUB: result = A-B mod 2^WIDTH; C = borrow (A<B unsigned); V = signed overflow (A,B differing sign, result sign != A sign).
- AND/OR/XOR: bitwise; C=0, V=0.
- SHL/SHR: logical shift of A by s = B[SHW-1:0]; B upper bits ignored.
  - C = last bit shifted out: A[WIDTH-s] for SHL, A[s-1] for SHR.
  - s=0 gives result=A, C=0. V=0.
- MUL: unsigned; C = 1 if acc[2W-1:W] != 0; V=0.
- All ops: Z = (result==0); N = result[WIDTH-1].
- Undefined inputs when in_valid=0 are never sampled.
- Reset mid-MUL: abort immediately, return to IDLE, no out_valid pulse after release.

Test Plan:
- WIDTH=4, A=0011, B=0001, out_ready=1, sel 000..100 issued back-to-back:
  - results 0100, 0010, 0001, 0011, 0010;
  - one result per cycle, each 1 cycle after accept;
  - flags Z=0, C=0, V=0 throughout.
- Flags:
  - ADD A=0111 B=0001 -> 1000, N=1, V=1, C=0.
  - ADD 1111+0001 -> 0000, Z=1, C=1.
  - SUB A=0001 B=0011 -> 1110, C=1, N=1.
- Shifts:
  - SHL A=1001 B=0001 -> 0010, C=1.
  - SHR A=1001 B=0010 -> 0010, C=0.
  - SHR A=1001 B=0100 (s=0) -> 1001, C=0.
- MUL A=0011 B=0101:
  - busy high 4 cycles; out_valid rises 5 edges after accept; result=1111, C=0.
  - MUL 1111x1111 -> 0001, C=1.
  - in_ready=0 during busy.
- Backpressure: ADD accepted with out_ready=0 for 3 cycles:
  - result and flags stable, in_ready=0, a second in_valid is not accepted;
  - out_ready=1 drains, and a new op offered on that edge is accepted.
- Reset mid-operation:
  - assert rst 2 cycles into a MUL, asynchronously between edges -> out_valid, busy and result go to 0 immediately;
  - after release, in_ready=1 and no stale result appears.
